blake2_mix_seq: RTL and testbench

//  Round sequencer directly upstream of blake2_G. Holds the 16-word working vector v and
//  the 16-word message block m, and drives one shared blake2_G instance, one G call per

---
 rtl/blake2_pkg.sv | 39 +++
 rtl/blake2_m_select.sv | 27 ++
 rtl/blake2_mix_seq.sv | 134 +++++++++++++
 tb/tb_blake2_mix_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// rtl/blake2_pkg.sv - shared constants for the BLAKE2b round sequencer: sigma schedule, G index tables, FSM states
package blake2_pkg;

    localparam int WORD_W    = 64;
    localparam int NUM_WORDS = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MIX  = 1'b1;

    // Index tables packed one nibble per G step; nibble k holds the v index for g_idx k.
    localparam logic [31:0] G_IA = 32'h32103210;
    localparam logic [31:0] G_IB = 32'h47657654;
    localparam logic [31:0] G_IC = 32'h98BABA98;
    localparam logic [31:0] G_ID = 32'hEDCFFEDC;

    function automatic logic [3:0] nib32(input logic [31:0] tbl, input logic [2:0] idx);
        return tbl[{idx, 2'b00} +: 4];
    endfunction

    // Sigma row r, nibble k = SIGMA[r][k].
    function automatic logic [63:0] sigma_row(input logic [3:0] r);
        logic [63:0] row;
        case (r)
            4'd0:    row = 64'hFEDCBA9876543210;
            4'd1:    row = 64'h357B20C16DF984AE;
            4'd2:    row = 64'h491763EADF250C8B;
            4'd3:    row = 64'h8F04A562EBCD1397;
            4'd4:    row = 64'hD386CB1EFA427509;
            4'd5:    row = 64'h91EF57D438B0A6C2;
            4'd6:    row = 64'hB8293670A4DEF15C;
            4'd7:    row = 64'hA2684F05931CE7BD;
            4'd8:    row = 64'h5A417D2C803B9EF6;
            4'd9:    row = 64'h0DC3E9BF5167482A;
            default: row = 64'hFEDCBA9876543210;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/blake2_m_select.sv
// rtl/blake2_m_select.sv - picks the two message words for the current G call from the sigma schedule
module blake2_m_select
    import blake2_pkg::*;
(
    input  logic [1023:0] m_reg,
    input  logic [3:0]    round,
    input  logic [2:0]    g_idx,
    output logic [63:0]   m0,
    output logic [63:0]   m1
);

    logic [3:0]  row;
    logic [63:0] sig;
    logic [3:0]  s0;
    logic [3:0]  s1;

    always_comb begin
        // rounds 10 and 11 reuse sigma rows 0 and 1
        row = (round >= 4'd10) ? round - 4'd10 : round;
        sig = sigma_row(row);
        s0  = sig[{g_idx, 3'b000} +: 4];
        s1  = sig[{g_idx, 3'b100} +: 4];
        m0  = m_reg[{s0, 6'd0} +: 64];
        m1  = m_reg[{s1, 6'd0} +: 64];
    end

endmodule

// File: rtl/blake2_mix_seq.sv
// rtl/blake2_mix_seq.sv - BLAKE2b round sequencer driving one shared G; BLAKE2_G_OUT_REG_EN adds a G result register
module blake2_mix_seq
    import blake2_pkg::*;
#(
    parameter int NUM_ROUNDS = 12
)
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic [1023:0] v_in,
    input  logic [1023:0] m_in,
    output logic          ready,
    output logic          v_valid,
    output logic [1023:0] v_out,
    output logic [63:0]   g_a,
    output logic [63:0]   g_b,
    output logic [63:0]   g_c,
    output logic [63:0]   g_d,
    output logic [63:0]   g_m0,
    output logic [63:0]   g_m1,
    input  logic [63:0]   g_a_prim,
    input  logic [63:0]   g_b_prim,
    input  logic [63:0]   g_c_prim,
    input  logic [63:0]   g_d_prim
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    logic [0:0]                        state;
    logic [NUM_WORDS-1:0][WORD_W-1:0]  v_reg;
    logic [1023:0]                     m_reg;
    logic [3:0]                        round;
    logic [2:0]                        g_idx;
    logic [3:0]                        ia, ib, ic, id;
    logic [63:0]                       m0, m1;
    logic [63:0]                       wa, wb, wc, wd;
    logic                              wb_en;
    logic                              mixing;

    assign ia     = nib32(G_IA, g_idx);
    assign ib     = nib32(G_IB, g_idx);
    assign ic     = nib32(G_IC, g_idx);
    assign id     = nib32(G_ID, g_idx);
    assign mixing = (state == ST_MIX);

    blake2_m_select u_m_select (
        .m_reg (m_reg),
        .round (round),
        .g_idx (g_idx),
        .m0    (m0),
        .m1    (m1)
    );

    assign g_a   = mixing ? v_reg[ia] : '0;
    assign g_b   = mixing ? v_reg[ib] : '0;
    assign g_c   = mixing ? v_reg[ic] : '0;
    assign g_d   = mixing ? v_reg[id] : '0;
    assign g_m0  = mixing ? m0 : '0;
    assign g_m1  = mixing ? m1 : '0;
    assign v_out = v_reg;

`ifdef BLAKE2_G_OUT_REG_EN
    // phase 0 issues and captures G, phase 1 writes back; g_idx is held so g_* stay stable
    logic         phase;
    logic [255:0] g_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 1'b0;
            g_res <= '0;
        end else if (mixing) begin
            phase <= ~phase;
            if (!phase) begin
                g_res <= {g_a_prim, g_b_prim, g_c_prim, g_d_prim};
            end
        end else begin
            phase <= 1'b0;
        end
    end

    assign {wa, wb, wc, wd} = g_res;
    assign wb_en            = mixing && phase;
`else
    assign {wa, wb, wc, wd} = {g_a_prim, g_b_prim, g_c_prim, g_d_prim};
    assign wb_en            = mixing;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            v_valid <= 1'b0;
            v_reg   <= '0;
            m_reg   <= '0;
            round   <= '0;
            g_idx   <= '0;
        end else if (state == ST_IDLE) begin
            if (init && ready) begin
                state   <= ST_MIX;
                ready   <= 1'b0;
                v_valid <= 1'b0;
                v_reg   <= v_in;
                m_reg   <= m_in;
                round   <= '0;
                g_idx   <= '0;
            end
        end else if (wb_en) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (4'(i) == ia) begin
                    v_reg[i] <= wa;
                end else if (4'(i) == ib) begin
                    v_reg[i] <= wb;
                end else if (4'(i) == ic) begin
                    v_reg[i] <= wc;
                end else if (4'(i) == id) begin
                    v_reg[i] <= wd;
                end
            end
            g_idx <= g_idx + 3'd1;
            if (g_idx == 3'd7) begin
                if (round == LAST_ROUND) begin
                    state   <= ST_IDLE;
                    ready   <= 1'b1;
                    v_valid <= 1'b1;
                    round   <= '0;
                end else begin
                    round <= round + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_blake2_mix_seq.sv
// tb/tb_blake2_mix_seq.sv - directed bench for blake2_mix_seq with a behavioural G and RFC 7693 "abc" vectors
module tb_blake2_mix_seq;

`ifdef BLAKE2_G_OUT_REG_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam int SIG [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    localparam int GI [8][4] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
    };

    logic          tb_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          init = 1'b0;
    logic          init1 = 1'b0;
    logic [1023:0] v_in = '0;
    logic [1023:0] m_in = '0;
    logic          ready, v_valid, ready1, v_valid1;
    logic [1023:0] v_out, v_out1;
    logic [63:0]   g_a, g_b, g_c, g_d, g_m0, g_m1;
    logic [63:0]   g_a_prim, g_b_prim, g_c_prim, g_d_prim;
    logic [63:0]   g1_a, g1_b, g1_c, g1_d, g1_m0, g1_m1;
    logic [63:0]   g1_a_prim, g1_b_prim, g1_c_prim, g1_d_prim;

    int n_chk = 0;
    int n_err = 0;

    logic [1023:0] v_abc, m_abc, m_tag;
    logic [63:0]   rfc_h [8];

    always #5 tb_clk = ~tb_clk;

    function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

    function automatic logic [255:0] g_fn(input logic [63:0] a0, b0, c0, d0, x, y);
        logic [63:0] a, b, c, d;
        a = a0 + b0 + x;  d = rotr(d0 ^ a, 32);
        c = c0 + d;       b = rotr(b0 ^ c, 24);
        a = a + b + y;    d = rotr(d ^ a, 16);
        c = c + d;        b = rotr(b ^ c, 63);
        return {a, b, c, d};
    endfunction

    function automatic logic [1023:0] ref_compress(input logic [1023:0] vi, mi, input int nr);
        logic [63:0]   v [16];
        logic [63:0]   m [16];
        logic [1023:0] o;
        for (int i = 0; i < 16; i++) begin
            v[i] = vi[64*i +: 64];
            m[i] = mi[64*i +: 64];
        end
        for (int rr = 0; rr < nr; rr++) begin
            for (int j = 0; j < 8; j++) begin
                {v[GI[j][0]], v[GI[j][1]], v[GI[j][2]], v[GI[j][3]]} =
                    g_fn(v[GI[j][0]], v[GI[j][1]], v[GI[j][2]], v[GI[j][3]],
                         m[SIG[rr % 10][2*j]], m[SIG[rr % 10][2*j+1]]);
            end
        end
        for (int i = 0; i < 16; i++) o[64*i +: 64] = v[i];
        return o;
    endfunction

    assign {g_a_prim, g_b_prim, g_c_prim, g_d_prim}     = g_fn(g_a, g_b, g_c, g_d, g_m0, g_m1);
    assign {g1_a_prim, g1_b_prim, g1_c_prim, g1_d_prim} = g_fn(g1_a, g1_b, g1_c, g1_d, g1_m0, g1_m1);

    blake2_mix_seq dut (
        .clk(tb_clk), .reset_n(reset_n), .init(init), .v_in(v_in), .m_in(m_in),
        .ready(ready), .v_valid(v_valid), .v_out(v_out),
        .g_a(g_a), .g_b(g_b), .g_c(g_c), .g_d(g_d), .g_m0(g_m0), .g_m1(g_m1),
        .g_a_prim(g_a_prim), .g_b_prim(g_b_prim), .g_c_prim(g_c_prim), .g_d_prim(g_d_prim)
    );

    blake2_mix_seq #(.NUM_ROUNDS(1)) dut1 (
        .clk(tb_clk), .reset_n(reset_n), .init(init1), .v_in(v_in), .m_in(m_in),
        .ready(ready1), .v_valid(v_valid1), .v_out(v_out1),
        .g_a(g1_a), .g_b(g1_b), .g_c(g1_c), .g_d(g1_d), .g_m0(g1_m0), .g_m1(g1_m1),
        .g_a_prim(g1_a_prim), .g_b_prim(g1_b_prim), .g_c_prim(g1_c_prim), .g_d_prim(g1_d_prim)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | v_out[64*i +: 64];
        check({nm, "_ready"}, 64'(ready), 64'd1);
        check({nm, "_v_valid"}, 64'(v_valid), 64'd0);
        check({nm, "_v_out_or"}, acc, 64'd0);
        check({nm, "_g_or"}, g_a | g_b | g_c | g_d | g_m0 | g_m1, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge tb_clk);
        reset_n = 1'b0;
        repeat (2) @(negedge tb_clk);
        reset_n = 1'b1;
        @(negedge tb_clk);
    endtask

    task automatic run_comp(input logic [1023:0] vi, mi, input int pa, pb, input bit chk_sigma,
                            input bit chk_digest, input string nm);
        logic [1023:0] exp;
        int cnt;
        bit done;
        exp = ref_compress(vi, mi, 12);
        @(negedge tb_clk);
        v_in = vi; m_in = mi; init = 1'b1;
        @(posedge tb_clk);
        #1 init = 1'b0;
        check({nm, "_busy_ready"}, 64'(ready), 64'd0);
        check({nm, "_busy_valid"}, 64'(v_valid), 64'd0);
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 12*8*STEP + 20) begin
            @(posedge tb_clk);
            #1 cnt++;
            init = (cnt == pa || cnt == pb);
            if (chk_sigma && cnt == 9*STEP) begin
                check({nm, "_r1g1_m0"}, g_m0, mi[64*4 +: 64]);
                check({nm, "_r1g1_m1"}, g_m1, mi[64*8 +: 64]);
            end
            if (chk_sigma && cnt == 80*STEP) begin
                check({nm, "_r10_m0"}, g_m0, mi[64*0 +: 64]);
                check({nm, "_r10_m1"}, g_m1, mi[64*1 +: 64]);
            end
            if (chk_sigma && cnt == 88*STEP) begin
                check({nm, "_r11_m0"}, g_m0, mi[64*14 +: 64]);
                check({nm, "_r11_m1"}, g_m1, mi[64*10 +: 64]);
            end
            if (v_valid) done = 1'b1;
        end
        init = 1'b0;
        check({nm, "_latency"}, 64'(cnt), 64'(12*8*STEP));
        check({nm, "_done_ready"}, 64'(ready), 64'd1);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_v%0d", nm, i), v_out[64*i +: 64], exp[64*i +: 64]);
        if (chk_digest) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("%s_h%0d", nm, i),
                      vi[64*i +: 64] ^ v_out[64*i +: 64] ^ v_out[64*(i+8) +: 64], rfc_h[i]);
        end
        repeat (3) @(negedge tb_clk);
        check({nm, "_valid_hold"}, 64'(v_valid), 64'd1);
        check({nm, "_hold_v0"}, v_out[63:0], exp[63:0]);
        check({nm, "_idle_g"}, g_a | g_m0, 64'd0);
    endtask

    initial begin
        logic [63:0] abc_w [16];
        logic [1023:0] v2, exp1;
        int cnt;
        abc_w = '{64'h6a09e667f2bdc948, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                  64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179,
                  64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                  64'h510e527fade682d2, 64'h9b05688c2b3e6c1f, 64'he07c265404be4294, 64'h5be0cd19137e2179};
        rfc_h = '{64'h0D4D1C983FA580BA, 64'hE9F6129FB697276A, 64'hB7C45A68142F214C, 64'hD1A2FFDB6FBB124B,
                  64'h2D79AB2A39C5877D, 64'h95CC3345DED552C2, 64'h5A92F1DBA88AD318, 64'h239900D4ED8623B9};
        for (int i = 0; i < 16; i++) begin
            v_abc[64*i +: 64] = abc_w[i];
            m_tag[64*i +: 64] = 64'h0123456789abcd00 | 64'(i);
        end
        m_abc = '0;
        m_abc[63:0] = 64'h0000000000636261;

        repeat (3) @(negedge tb_clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge tb_clk);
        check_idle_outputs("release");

        v2 = '0;
        v2[64*0 +: 64]  = 64'h6a09e667f2bdc948;
        v2[64*4 +: 64]  = 64'h510e527fade682d1;
        v2[64*8 +: 64]  = 64'h6a09e667f3bcc908;
        v2[64*12 +: 64] = 64'h510e527fade68251;
        v_in = v2; m_in = '0; init = 1'b1;
        @(posedge tb_clk);
        #1 init = 1'b0;
        repeat (STEP) @(posedge tb_clk);
        #1;
        check("g1_v0",  v_out[64*0 +: 64],  64'hf0c9aa0de38b1b89);
        check("g1_v4",  v_out[64*4 +: 64],  64'hbbdf863401fde49b);
        check("g1_v8",  v_out[64*8 +: 64],  64'he85eb23c42183d3d);
        check("g1_v12", v_out[64*12 +: 64], 64'h7111fd8b6445099d);
        check("g1_v1",  v_out[64*1 +: 64],  64'd0);
        check("g1_v13", v_out[64*13 +: 64], 64'd0);
        do_reset();

        run_comp(v_abc, m_abc, -1, -1, 1'b0, 1'b1, "abc");
        run_comp(v_abc, m_abc, 24*STEP + 1, 88*STEP + 2, 1'b0, 1'b1, "busy_init");

        @(negedge tb_clk);
        v_in = v_abc; m_in = m_abc; init = 1'b1;
        @(posedge tb_clk);
        #1 init = 1'b0;
        repeat (40*STEP + 3) @(posedge tb_clk);
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("abort");
        @(negedge tb_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge tb_clk);
        check_idle_outputs("abort_rel");
        run_comp(v_abc, m_abc, -1, -1, 1'b0, 1'b1, "after_abort");

        run_comp(v_abc, m_tag, -1, -1, 1'b1, 1'b0, "tagged");

        exp1 = ref_compress(v_abc, m_abc, 1);
        @(negedge tb_clk);
        v_in = v_abc; m_in = m_abc; init1 = 1'b1;
        @(posedge tb_clk);
        #1 init1 = 1'b0;
        cnt = 0;
        while (!v_valid1 && cnt < 8*STEP + 20) begin
            @(posedge tb_clk);
            #1 cnt++;
        end
        check("nr1_latency", 64'(cnt), 64'(8*STEP));
        check("nr1_ready", 64'(ready1), 64'd1);
        for (int i = 0; i < 16; i++)
            check($sformatf("nr1_v%0d", i), v_out1[64*i +: 64], exp1[64*i +: 64]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
